freq_meter: RTL

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// freq_meter: gated frequency and period meter for an asynchronous input.
//
// Counts sig_in rising edges over back-to-back windows of GATE_CYCLES clocks
// and measures the clock count between the two most recent rising edges.
//
// Ports:
//   CLK100MHZ     in   sole clock, all state updates on its rising edge
//   rst           in   synchronous active-high reset
//   sig_in        in   signal under measurement, asynchronous to CLK100MHZ
//   enable        in   1 = measure continuously, 0 = idle
//   freq_count    out  rising edges counted in the last completed window
//   count_valid   out  one-cycle pulse when freq_count updates
//   overflow      out  last completed window saturated its edge count
//   period_cycles out  clocks between the two most recent rising edges
//   period_valid  out  one-cycle pulse when period_cycles updates
//   edge_seen     out  toggles on every detected rising edge
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned CNT_W       = 27,
    parameter int unsigned PER_W       = 32
) (
    input  logic             CLK100MHZ,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] freq_count,
    output logic             count_valid,
    output logic             overflow,
    output logic [PER_W-1:0] period_cycles,
    output logic             period_valid,
    output logic             edge_seen
);

    typedef enum logic [0:0] {StIdle, StGate} state_e;

    localparam logic [31:0]      GateLast = 32'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [PER_W-1:0] PerMax   = '1;

    state_e state_q, state_d;

    logic sync1_q, sync2_q, sync3_q;
    logic rise;

    logic [31:0]      gate_timer_q, gate_timer_d;
    logic [CNT_W-1:0] edge_ctr_q, edge_ctr_d;
    // Sticky: a rise was dropped because edge_ctr was already at CntMax.
    logic             edge_sat_q, edge_sat_d;
    logic [PER_W-1:0] per_ctr_q, per_ctr_d;
    logic             armed_q, armed_d;

    logic [CNT_W-1:0] freq_count_d;
    logic             count_valid_d, overflow_d;
    logic [PER_W-1:0] period_cycles_d;
    logic             period_valid_d;

    // Edge total and saturation status including a rise in the current cycle.
    logic [CNT_W-1:0] edge_next;
    logic             sat_next;

    assign rise      = sync2_q & ~sync3_q;
    assign edge_next = (rise && edge_ctr_q != CntMax) ? edge_ctr_q + 1'b1 : edge_ctr_q;
    assign sat_next  = edge_sat_q | (rise & (edge_ctr_q == CntMax));

    always_comb begin
        state_d         = state_q;
        gate_timer_d    = gate_timer_q;
        edge_ctr_d      = edge_ctr_q;
        edge_sat_d      = edge_sat_q;
        per_ctr_d       = per_ctr_q;
        armed_d         = armed_q;
        freq_count_d    = freq_count;
        count_valid_d   = 1'b0;
        overflow_d      = overflow;
        period_cycles_d = period_cycles;
        period_valid_d  = 1'b0;

        case (state_q)
            StIdle: begin
                gate_timer_d = '0;
                edge_ctr_d   = '0;
                edge_sat_d   = 1'b0;
                per_ctr_d    = '0;
                armed_d      = 1'b0;
                if (enable) begin
                    state_d = StGate;
                end
            end
            StGate: begin
                if (!enable) begin
                    // Partial window is discarded; published results hold.
                    state_d      = StIdle;
                    gate_timer_d = '0;
                    edge_ctr_d   = '0;
                    edge_sat_d   = 1'b0;
                    per_ctr_d    = '0;
                    armed_d      = 1'b0;
                end else begin
                    gate_timer_d = gate_timer_q + 1'b1;
                    edge_ctr_d   = edge_next;
                    edge_sat_d   = sat_next;
                    per_ctr_d    = (per_ctr_q == PerMax) ? per_ctr_q : per_ctr_q + 1'b1;

                    if (rise) begin
                        per_ctr_d = PER_W'(1);
                        armed_d   = 1'b1;
                        if (armed_q) begin
                            period_cycles_d = per_ctr_q;
                            period_valid_d  = 1'b1;
                        end
                    end

                    // Window boundary: publish and restart with no dead cycle.
                    if (gate_timer_q == GateLast) begin
                        freq_count_d  = edge_next;
                        overflow_d    = sat_next;
                        count_valid_d = 1'b1;
                        gate_timer_d  = '0;
                        edge_ctr_d    = '0;
                        edge_sat_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q       <= StIdle;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            gate_timer_q  <= '0;
            edge_ctr_q    <= '0;
            edge_sat_q    <= 1'b0;
            per_ctr_q     <= '0;
            armed_q       <= 1'b0;
            freq_count    <= '0;
            count_valid   <= 1'b0;
            overflow      <= 1'b0;
            period_cycles <= '0;
            period_valid  <= 1'b0;
            edge_seen     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sig_in;
            sync2_q       <= sync1_q;
            sync3_q       <= sync2_q;
            gate_timer_q  <= gate_timer_d;
            edge_ctr_q    <= edge_ctr_d;
            edge_sat_q    <= edge_sat_d;
            per_ctr_q     <= per_ctr_d;
            armed_q       <= armed_d;
            freq_count    <= freq_count_d;
            count_valid   <= count_valid_d;
            overflow      <= overflow_d;
            period_cycles <= period_cycles_d;
            period_valid  <= period_valid_d;
            edge_seen     <= edge_seen ^ rise;
        end
    end

endmodule
